// File: rtl/pes_gray_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// pes_gray_seq_ctrl_if
// Groups the command and output-stream signals of the Gray sequencer.
//
//   start      : begin a sequence (taken only while the sequencer is idle)
//   stop       : abort a running sequence
//   up_dn      : count direction, 1 = increment, 0 = decrement
//   start_val  : first binary value of the sequence
//   end_val    : last binary value of the sequence
//   out_ready  : consumer accepts the presented code
//   out_valid  : out_bin / out_g hold a valid code
//   out_bin    : current binary value
//   out_g      : Gray code of out_bin
//   busy       : sequencer is running or finishing
//   done       : one-cycle pulse after the final code is accepted
//
// master : the side that issues commands and consumes codes
// slave  : the sequencer itself
// -----------------------------------------------------------------------------
interface pes_gray_seq_ctrl_if #(
    parameter int W = 4
);
    logic         start;
    logic         stop;
    logic         up_dn;
    logic [W-1:0] start_val;
    logic [W-1:0] end_val;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] out_bin;
    logic [W-1:0] out_g;
    logic         busy;
    logic         done;

    modport master (
        output start, stop, up_dn, start_val, end_val, out_ready,
        input  out_valid, out_bin, out_g, busy, done
    );

    modport slave (
        input  start, stop, up_dn, start_val, end_val, out_ready,
        output out_valid, out_bin, out_g, busy, done
    );
endinterface

// File: rtl/pes_gray_seq_ctrl.sv
// -----------------------------------------------------------------------------
// pes_gray_seq_ctrl
// Steps a W-bit binary count from start_val to end_val (up or down, modulo
// 2^W) and presents each value with its Gray code on a valid/ready stream.
// One code is issued per accepted transfer; done pulses once after end_val
// has been accepted. stop aborts without done.
//
// Ports:
//   clk  : system clock, all state changes on the rising edge
//   rst  : synchronous, active-high reset
//   bus  : pes_gray_seq_ctrl_if.slave (commands in, code stream out)
//
// W must match the W of the connected interface instance.
// -----------------------------------------------------------------------------
module pes_gray_seq_ctrl #(
    parameter int W = 4
) (
    input  logic               clk,
    input  logic               rst,
    pes_gray_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    logic [W-1:0] end_q;      // latched end value
    logic         up_q;       // latched direction
    logic [W-1:0] bin_q;
    logic [W-1:0] g_q;
    logic         valid_q;
    logic         done_q;
    logic         busy_q;

    logic [W-1:0] bin_nxt;
    logic         xfer;

    function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Wrap-around falls out of the W-bit truncation.
    assign bin_nxt = up_q ? bin_q + W'(1) : bin_q - W'(1);
    assign xfer    = valid_q & bus.out_ready;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            end_q   <= '0;
            up_q    <= 1'b0;
            bin_q   <= '0;
            g_q     <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            // done is a pulse: cleared unless explicitly set below.
            done_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bin_q   <= bus.start_val;
                        g_q     <= to_gray(bus.start_val);
                        end_q   <= bus.end_val;
                        up_q    <= bus.up_dn;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state   <= RUN;
                    end
                end

                RUN: begin
                    // stop wins over end-of-sequence: a coincident transfer
                    // is completed but never produces done.
                    if (bus.stop) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end else if (xfer) begin
                        if (bin_q == end_q) begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state   <= DONE;
                        end else begin
                            // bin and Gray move on the same edge so they
                            // never disagree.
                            bin_q <= bin_nxt;
                            g_q   <= to_gray(bin_nxt);
                        end
                    end
                end

                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_bin   = bin_q;
    assign bus.out_g     = g_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_pes_gray_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pes_gray_seq_ctrl
// Scoreboard bench for pes_gray_seq_ctrl. Stimulus pushes the expected code
// list of each sequence into a queue; a negedge monitor pops and compares on
// every accepted transfer and tracks done / busy / hold behaviour.
// -----------------------------------------------------------------------------
module tb_pes_gray_seq_ctrl;

    localparam int W = 4;
    localparam int M = 1 << W;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pes_gray_seq_ctrl_if #(.W(W)) bus ();

    pes_gray_seq_ctrl #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [W-1:0] bin;
        logic [W-1:0] g;
        bit           last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_it;

    int n_checks = 0;
    int n_fail   = 0;

    int gray_tab[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};
    bit ready_pat[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    task automatic check(input bit ok, input string name, input int act, input int req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int ref_gray(input int b);
        return (b ^ (b >> 1)) % M;
    endfunction

    // Expected code list from the sequence-length and step rules.
    function automatic void push_seq(input int s, input int e, input bit up);
        int len;
        len = (((up ? e - s : s - e) % M) + M) % M + 1;
        for (int i = 0; i < len; i++) begin
            exp_t it;
            int   v;
            v       = (((s + (up ? i : -i)) % M) + M) % M;
            it.bin  = W'(v);
            it.g    = W'(ref_gray(v));
            it.last = (i == len - 1);
            exp_q.push_back(it);
        end
    endfunction

    // ---------------------------------------------------------------- monitor
    bit           exp_done = 1'b0;
    bit           exp_idle = 1'b0;
    bit           exp_hold = 1'b0;
    logic [W-1:0] held_bin;

    always @(negedge clk) begin
        bit nd, ni, nh;
        if (rst !== 1'b0) begin
            exp_done = 1'b0;
            exp_idle = 1'b0;
            exp_hold = 1'b0;
            exp_q.delete();
        end else begin
            nd = 1'b0;
            ni = 1'b0;
            nh = 1'b0;
            check(bus.out_g === W'(ref_gray(int'(bus.out_bin))), "gray_rule",
                  int'(bus.out_g), ref_gray(int'(bus.out_bin)));
            check(bus.done === exp_done, "done", int'(bus.done), int'(exp_done));
            if (exp_idle) begin
                check(bus.busy === 1'b0, "busy_low", int'(bus.busy), 0);
                check(bus.out_valid === 1'b0, "valid_low", int'(bus.out_valid), 0);
            end
            if (exp_hold)
                check(bus.out_valid === 1'b1 && bus.out_bin === held_bin, "hold",
                      int'(bus.out_bin), int'(held_bin));
            if (exp_done)
                ni = 1'b1;
            if (bus.out_valid === 1'b1) begin
                if (bus.out_ready === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_transfer", int'(bus.out_bin), -1);
                    end else begin
                        mon_it = exp_q.pop_front();
                        check(bus.out_bin === mon_it.bin, "xfer_bin",
                              int'(bus.out_bin), int'(mon_it.bin));
                        check(bus.out_g === mon_it.g, "xfer_gray",
                              int'(bus.out_g), int'(mon_it.g));
                        if (mon_it.last && bus.stop !== 1'b1)
                            nd = 1'b1;
                    end
                end else if (bus.stop !== 1'b1) begin
                    nh       = 1'b1;
                    held_bin = bus.out_bin;
                end
                if (bus.stop === 1'b1) begin
                    ni = 1'b1;
                    exp_q.delete();
                end
            end
            exp_done = nd;
            exp_idle = ni;
            exp_hold = nh;
        end
    end

    // --------------------------------------------------------------- stimulus
    task automatic start_seq(input int s, input int e, input bit up);
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.start_val = W'(s);
        bus.end_val   = W'(e);
        bus.up_dn     = up;
        @(posedge clk); #1;
        bus.start     = 1'b0;
    endtask

    // mode 0: always ready, 1: random ready + occasional stop, 2: ready pattern
    task automatic run_wait(input int mode, input int abort_at, input int budget);
        int k;
        bit fin;
        fin = 1'b0;
        for (k = 0; k < budget && !fin; k++) begin
            case (mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ($urandom_range(0, 3) != 0);
                default: bus.out_ready = (k < 6) ? ready_pat[k] : 1'b1;
            endcase
            bus.stop = (abort_at >= 0 && bus.out_valid === 1'b1 && int'(bus.out_bin) == abort_at)
                       || (mode == 1 && $urandom_range(0, 24) == 0);
            @(posedge clk); #1;
            if (bus.busy === 1'b0)
                fin = 1'b1;
        end
        bus.stop = 1'b0;
        check(fin, "seq_terminates", k, budget);
        check(exp_q.size() == 0, "all_codes_seen", exp_q.size(), 0);
    endtask

    initial begin
        bit found;
        int s, e;
        bit up;

        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.up_dn     = 1'b0;
        bus.start_val = '0;
        bus.end_val   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check(bus.out_valid === 1'b0, "rst_valid", int'(bus.out_valid), 0);
        check(bus.out_bin === '0, "rst_bin", int'(bus.out_bin), 0);
        check(bus.out_g === '0, "rst_gray", int'(bus.out_g), 0);
        check(bus.busy === 1'b0, "rst_busy", int'(bus.busy), 0);
        check(bus.done === 1'b0, "rst_done", int'(bus.done), 0);
        rst = 1'b0;

        // Full up-count against the literal Gray table.
        for (int i = 0; i < 16; i++) begin
            exp_t it;
            it.bin  = W'(i);
            it.g    = W'(gray_tab[i]);
            it.last = (i == 15);
            exp_q.push_back(it);
        end
        start_seq(0, 15, 1'b1);
        run_wait(0, -1, 40);

        // Wrap-around both directions.
        push_seq(14, 1, 1'b1);
        start_seq(14, 1, 1'b1);
        run_wait(0, -1, 20);
        push_seq(1, 14, 1'b0);
        start_seq(1, 14, 1'b0);
        run_wait(0, -1, 20);

        // Backpressure with ready pattern 0,0,1,0,1,1.
        push_seq(3, 5, 1'b1);
        start_seq(3, 5, 1'b1);
        run_wait(2, -1, 20);

        // Single code, plus a start pulse while busy that must be ignored.
        push_seq(10, 10, 1'b1);
        start_seq(10, 10, 1'b1);
        bus.out_ready = 1'b0;
        bus.start     = 1'b1;
        bus.start_val = W'(2);
        bus.end_val   = W'(6);
        bus.up_dn     = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        check(bus.out_valid === 1'b1 && bus.out_bin === W'(10), "no_reload",
              int'(bus.out_bin), 10);
        run_wait(0, -1, 20);

        // stop while idle has no effect.
        bus.stop = 1'b1;
        @(posedge clk); #1;
        bus.stop = 1'b0;
        check(bus.busy === 1'b0 && bus.out_valid === 1'b0, "stop_idle", int'(bus.busy), 0);

        // Abort at out_bin = 5, then a clean restart.
        push_seq(0, 15, 1'b1);
        start_seq(0, 15, 1'b1);
        run_wait(0, 5, 40);
        push_seq(7, 4, 1'b0);
        start_seq(7, 4, 1'b0);
        run_wait(0, -1, 20);

        // Reset mid-run at out_bin = 9, with a coincident start.
        push_seq(0, 15, 1'b1);
        start_seq(0, 15, 1'b1);
        bus.out_ready = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            if (bus.out_valid === 1'b1 && bus.out_bin === W'(9))
                found = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        check(found, "reach_bin9", int'(bus.out_bin), 9);
        rst           = 1'b1;
        bus.start     = 1'b1;
        bus.start_val = W'(3);
        bus.end_val   = W'(3);
        @(posedge clk); #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        check(bus.out_valid === 1'b0, "midrst_valid", int'(bus.out_valid), 0);
        check(bus.out_bin === '0, "midrst_bin", int'(bus.out_bin), 0);
        check(bus.out_g === '0, "midrst_gray", int'(bus.out_g), 0);
        check(bus.busy === 1'b0, "midrst_busy", int'(bus.busy), 0);
        check(bus.done === 1'b0, "midrst_done", int'(bus.done), 0);
        @(posedge clk); #1;
        check(bus.busy === 1'b0, "start_with_rst_ignored", int'(bus.busy), 0);

        // Randomised sequences with random backpressure and occasional stop.
        repeat (12) begin
            s  = $urandom_range(0, M - 1);
            e  = $urandom_range(0, M - 1);
            up = 1'($urandom_range(0, 1));
            push_seq(s, e, up);
            start_seq(s, e, up);
            run_wait(1, -1, 400);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pes_gray_seq_ctrl.md
Name: pes_gray_seq_ctrl

Overview:
- Sequencer that steps a W-bit binary count from a programmed start value to a programmed end value, in either direction.
- Converts each binary value to Gray code and presents it on a valid/ready output stream.
- Drives binary-to-Gray conversion for downstream consumers (Gray-coded pointers, encoder test patterns). One code is issued per accepted transfer.

Parameters:
- W, 4, width of the binary count and of the Gray code.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a sequence; honoured only in IDLE.
- stop  input  1  abort the running sequence.
- up_dn  input  1  direction: 1 = increment, 0 = decrement; sampled with start.
- start_val  input  W  first binary value; sampled with start.
- end_val  input  W  last binary value; sampled with start.
- out_ready  input  1  consumer accepts the current code.
- out_valid  output  1  out_bin and out_g hold a valid code.
- out_bin  output  W  current binary value.
- out_g  output  W  Gray code of out_bin.
- busy  output  1  high when the FSM is not in IDLE.
- done  output  1  one-cycle pulse after the end_val code is accepted.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; out_valid=0; out_bin=0; out_g=0; busy=0; done=0.
  - Internal end/direction registers are cleared to 0.
  - Reset overrides every other input in the same cycle, including mid-sequence; an in-flight code is dropped.
- Gray rule: out_g = out_bin XOR (out_bin >> 1), bitwise over W bits.
  - out_g is registered and updated in the same edge as out_bin.
  - out_bin and out_g never disagree in any cycle.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1: load out_bin=start_val and out_g=gray(start_val); latch end_val and up_dn; set out_valid=1; go to RUN.
  - Latency: start sampled at edge N, so the first code is valid after edge N.
  - If start=0, all outputs hold and out_valid=0.
- RUN:
  - Transfer occurs on an edge where out_valid=1 and out_ready=1.
  - No transfer (out_ready=0): out_bin, out_g and out_valid are held stable; values never change while valid and unaccepted.
  - Transfer with out_bin != latched end: out_bin becomes out_bin+1 (up) or out_bin-1 (down), modulo 2^W; out_valid stays 1.
    - Wrap-around is natural, e.g. W=4 up: 15 -> 0; down: 0 -> 15.
    - Back-to-back transfers give one code per cycle.
  - Transfer with out_bin == latched end: out_valid=0, done=1 for one cycle, go to DONE.
- DONE: done returns to 0 and the FSM goes to IDLE on the next edge. start is ignored in DONE.
- Sequence length:
  - start_val == end_val issues exactly one code.
  - Otherwise (|end-start| mod 2^W in the selected direction) + 1 codes are issued.
- stop (RUN only): on the next edge out_valid=0 and state goes to IDLE; done is not asserted.
  - If stop coincides with a transfer, that transfer counts as completed, but the FSM still aborts: no further codes and no done, even if that code was end_val.
  - stop in IDLE or DONE has no effect.
- start while busy is ignored; start_val, end_val and up_dn are not re-sampled.
- busy is 1 in RUN and DONE, 0 in IDLE.

Test Plan:
- Reset then start with start_val=0, end_val=15, up_dn=1, out_ready=1: 16 consecutive codes out_g = 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8. done pulses one cycle after code 8; busy falls the following cycle.
- Wrap-around: start_val=14, end_val=1, up_dn=1 gives out_bin 14,15,0,1 and out_g 9,8,0,1. Down direction with start_val=1, end_val=14 gives out_bin 1,0,15,14.
- Backpressure: start_val=3, end_val=5, out_ready toggled 0,0,1,0,1,1: out_bin stays 3 (out_g=2) through both stalls, then advances 4 (out_g=6), held, 5 (out_g=7). Exactly 3 transfers, then done.
- Single code: start_val=end_val=10 gives one transfer with out_g=15, then done. A start pulse asserted while busy is ignored: no reload, no extra codes.
- Abort: during a 0 to 15 run, assert stop together with the transfer of out_bin=5. out_valid is 0 next cycle, done is never asserted, and busy is 0. A new start then begins cleanly from its own start_val.
- Reset mid-run: rst=1 while out_bin=9 with out_valid=1 gives all outputs 0 after the edge. start in the same cycle as rst is ignored.
